p0_wb_packer: RTL and testbench

//  Receiving end of the engine's port-0 writeback stream (dma_p0_writes_en / dma_p0_ib_data).

---
 rtl/p0_wb_packer.sv | 170 +++++++++++++++++
 tb/tb_p0_wb_packer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/p0_wb_packer.sv
// Port-0 writeback packer: gathers 16-bit engine results into BURST_LEN-lane words,
// tags each with lane mask and DRAM address, and queues them in a 2-entry FIFO for DMA.

module p0_wb_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr,
  input  logic [15:0] d,
  output logic [15:0] q,
  output logic        m,
  output logic [15:0] q_nxt,
  output logic        m_nxt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      m <= 1'b0;
    end else if (clr) begin
      q <= '0;
      m <= 1'b0;
    end else if (wr) begin
      q <= d;
      m <= 1'b1;
    end
  end

  // value this lane contributes to a word committed in the current cycle
  assign q_nxt = wr ? d : q;
  assign m_nxt = wr | m;
endmodule

module p0_wb_packer #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [15:0]            wr_data,
  input  logic                   flush,
  input  logic                   base_load,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*BURST_LEN-1:0] out_data,
  output logic [BURST_LEN-1:0]   out_mask,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            word_cnt
);
  localparam int LC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef struct packed {
    logic [BURST_LEN-1:0][15:0] data;
    logic [BURST_LEN-1:0]       mask;
    logic [ADDR_W-1:0]          addr;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} fst_t;

  logic [LC_W-1:0]            lane_cnt;
  logic [ADDR_W-1:0]          addr_ptr;
  logic [BURST_LEN-1:0]       lane_wr;
  logic [BURST_LEN-1:0][15:0] lane_q, lane_q_nxt;
  logic [BURST_LEN-1:0]       lane_m, lane_m_nxt;
  logic                       wr_acc, wr_last, commit, pop, clr;
  ent_t                       new_ent, head, tail;
  fst_t                       state, state_nxt;
  logic                       head_ld, head_from_tail, tail_ld;

  // base_load wins: a write in the same cycle is dropped
  assign wr_acc  = wr_en && !base_load;
  assign wr_last = wr_acc && (lane_cnt == LC_W'(BURST_LEN-1));
  assign commit  = !base_load && (wr_last || (flush && (wr_en || lane_cnt != '0)));
  assign pop     = out_valid && out_ready;
  assign clr     = base_load || commit;

  for (genvar i = 0; i < BURST_LEN; i++) begin : g_lane
    assign lane_wr[i] = wr_acc && (lane_cnt == LC_W'(i));
    p0_wb_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .wr    (lane_wr[i]),
      .d     (wr_data),
      .q     (lane_q[i]),
      .m     (lane_m[i]),
      .q_nxt (lane_q_nxt[i]),
      .m_nxt (lane_m_nxt[i])
    );
  end

  always_comb begin
    new_ent      = '0;
    new_ent.data = lane_q_nxt;
    new_ent.mask = lane_m_nxt;
    new_ent.addr = addr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      addr_ptr <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else if (base_load) begin
      lane_cnt <= '0;
      addr_ptr <= base_addr;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else if (commit) begin
      lane_cnt <= '0;
      addr_ptr <= addr_ptr + ADDR_W'(2*BURST_LEN);
      word_cnt <= word_cnt + 16'd1;
      if (state == TWO && !pop) overflow <= 1'b1;
    end else if (wr_acc) begin
      lane_cnt <= lane_cnt + LC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    unique case (state)
      EMPTY: if (commit) begin
        state_nxt = ONE;
        head_ld   = 1'b1;
      end
      ONE: begin
        if (commit && pop) head_ld = 1'b1;
        else if (commit) begin
          state_nxt = TWO;
          tail_ld   = 1'b1;
        end else if (pop) state_nxt = EMPTY;
      end
      TWO: if (pop) begin
        head_ld        = 1'b1;
        head_from_tail = 1'b1;
        tail_ld        = commit;
        if (!commit) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_ld) head <= head_from_tail ? tail : new_ent;
      if (tail_ld) tail <= new_ent;
    end
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = head.data;
  assign out_mask  = head.mask;
  assign out_addr  = head.addr;
  assign busy      = (lane_cnt != '0) || (state != EMPTY);
endmodule

// File: tb/tb_p0_wb_packer.sv
// Directed bench for p0_wb_packer: a reference packing model pushes expected words into a
// queue; a negedge monitor pops and compares on every DMA handshake.

module tb_p0_wb_packer;
  localparam int BL = 8;
  localparam int AW = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en, flush, base_load, out_ready;
  logic [15:0]     wr_data;
  logic [AW-1:0]   base_addr;
  logic            out_valid, busy, overflow;
  logic [16*BL-1:0] out_data;
  logic [BL-1:0]   out_mask;
  logic [AW-1:0]   out_addr;
  logic [15:0]     word_cnt;

  always #5 clk = ~clk;

  p0_wb_packer #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .out_addr(out_addr), .busy(busy), .overflow(overflow), .word_cnt(word_cnt)
  );

  typedef struct {
    logic [16*BL-1:0] d;
    logic [BL-1:0]    m;
    logic [AW-1:0]    a;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference packing state
  int               m_lane;
  logic [16*BL-1:0] m_buf;
  logic [BL-1:0]    m_mask;
  logic [AW-1:0]    m_addr;
  logic [15:0]      m_wcnt;
  logic             m_ovf;

  task automatic chk(input string tag, input logic [16*BL-1:0] obs, input logic [16*BL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_lane = 0; m_buf = '0; m_mask = '0; m_addr = '0; m_wcnt = '0; m_ovf = 1'b0;
  endtask

  // one clock: drive at posedge+1, update the model at the edge, check state after it
  task automatic step(input bit w, input logic [15:0] d, input bit f, input bit bl,
                      input logic [AW-1:0] ba);
    exp_t e;
    wr_en = w; wr_data = d; flush = f; base_load = bl; base_addr = ba;
    @(posedge clk);
    if (bl) begin
      m_addr = ba; m_lane = 0; m_buf = '0; m_mask = '0; m_wcnt = '0; m_ovf = 1'b0;
    end else begin
      if (w) begin
        m_buf[16*m_lane +: 16] = d;
        m_mask[m_lane] = 1'b1;
        m_lane++;
      end
      if (m_lane == BL || (f && m_lane != 0)) begin
        if (q.size() == 2) m_ovf = 1'b1;
        else begin
          e.d = m_buf; e.m = m_mask; e.a = m_addr;
          q.push_back(e);
        end
        m_addr = m_addr + AW'(2*BL);
        m_wcnt = m_wcnt + 16'd1;
        m_lane = 0; m_buf = '0; m_mask = '0;
      end
    end
    #1;
    wr_en = 1'b0; flush = 1'b0; base_load = 1'b0;
    chk("word_cnt", word_cnt, m_wcnt);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_lane != 0 || q.size() != 0));
    chk("out_valid", out_valid, q.size() != 0);
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // handshake monitor and hold-stability checker
  exp_t             mon_e;
  logic             hold = 1'b0;
  logic [16*BL-1:0] hd;
  logic [BL-1:0]    hm;
  logic [AW-1:0]    ha;

  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hd);
        chk("hold_mask", out_mask, hm);
        chk("hold_addr", out_addr, ha);
      end
      if (out_valid && out_ready) begin
        chk("word_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("out_data", out_data, mon_e.d);
          chk("out_mask", out_mask, mon_e.m);
          chk("out_addr", out_addr, mon_e.a);
        end
      end
      hold = out_valid && !out_ready;
      hd = out_data; hm = out_mask; ha = out_addr;
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; flush = 1'b0; base_load = 1'b0;
    wr_data = '0; base_addr = '0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_mask", out_mask, '0);
    chk("rst_addr", out_addr, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_wcnt", word_cnt, '0);
    rst_n = 1'b1;

    // T1: full word
    step(1'b0, '0, 1'b0, 1'b1, 30'h100);
    for (int i = 1; i <= 8; i++) wr(16'(i));
    idle(3);

    // T2: partial word via flush, then flush on an empty packer
    wr(16'hAAAA); wr(16'hBBBB); wr(16'hCCCC);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    idle(3);

    // T3: no DMA ready, third word overflows; then drain
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) wr(16'h3000 + 16'(i));
    idle(2);
    out_ready = 1'b1;
    idle(5);

    // T4: write+flush on lane 6 and on lane 7, plus a dropped write under base_load
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, 30'h2000);
    for (int i = 0; i < 6; i++) wr(16'h4000 + 16'(i));
    step(1'b1, 16'h4006, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) wr(16'h4100 + 16'(i));
    step(1'b1, 16'h4107, 1'b1, 1'b0, '0);
    idle(3);

    // T5: reset mid-operation with a queued word and 5 lanes packed
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) wr(16'h5000 + 16'(i));
    rst_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_data", out_data, '0);
    chk("t5_mask", out_mask, '0);
    chk("t5_addr", out_addr, '0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_wcnt", word_cnt, '0);
    q.delete();
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);

    // T6: streaming, then random backpressure, then address wrap
    step(1'b0, '0, 1'b0, 1'b1, 30'h0);
    for (int i = 0; i < 64; i++) wr(16'h6000 + 16'(i));
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0, '0);
    end
    out_ready = 1'b1;
    idle(6);
    step(1'b0, '0, 1'b0, 1'b1, 30'h3FFF_FFF0);
    for (int i = 0; i < 16; i++) wr(16'h7000 + 16'(i));

    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
